// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues single-outstanding word fetches
// to instruction memory, buffers returned words in a small FIFO and hands them
// to decode. Redirects from execute flush the buffer and squash in-flight fetches.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_raw,
    output logic [31:0] instr_pc
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    // IDLE: may issue; WAIT: good fetch in flight; DISCARD: squashed fetch in flight
    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DISCARD
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [31:0]        pc_q;
    logic [31:0]        req_pc_q;
    logic [31:0]        buf_raw [FIFO_DEPTH];
    logic [31:0]        buf_pc  [FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic               req_fire;
    logic               push;
    logic               pop;

    // Request is gated by occupancy at issue time, so a returning word always
    // has a free slot. Held low while reset is asserted.
    assign imem_req_valid = ~rst && (state_q == S_IDLE) && (count < DEPTH_C);
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid & imem_req_ready;

    assign instr_valid = (count != '0);
    assign instr_raw   = buf_raw[rd_ptr];
    assign instr_pc    = buf_pc[rd_ptr];

    // A redirect flushes the buffer, so a same-cycle dequeue is meaningless.
    assign pop = instr_valid & instr_ready & ~redirect_valid;

    // Next-state and enqueue decision; redirect overrides every other event.
    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_fire) begin
                    state_d = redirect_valid ? S_DISCARD : S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    state_d = imem_resp_valid ? S_IDLE : S_DISCARD;
                end else if (imem_resp_valid) begin
                    state_d = S_IDLE;
                    push    = 1'b1;
                end
            end
            S_DISCARD: begin
                if (imem_resp_valid) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register; reset returns to IDLE so a late response is ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // PC and address of the outstanding request.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
        end else if (redirect_valid) begin
            pc_q <= redirect_pc & 32'hFFFF_FFFC;
        end else if (req_fire) begin
            req_pc_q <= pc_q;
            pc_q     <= pc_q + 32'd4;
        end
    end

    // Instruction buffer: circular storage with occupancy count.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                buf_raw[i] <= '0;
                buf_pc[i]  <= '0;
            end
        end else if (redirect_valid) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                buf_raw[wr_ptr] <= imem_resp_data;
                buf_pc[wr_ptr]  <= req_pc_q;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed sequences, a redirect-alignment
// table and randomized traffic, all checked against a transaction-level model.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam int unsigned DEPTH  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_raw;
    logic [31:0] instr_pc;

    fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_raw      (instr_raw),
        .instr_pc       (instr_pc)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } ent_t;

    typedef struct {
        logic [31:0] target;
        logic        exp_valid;
        logic [31:0] exp_addr;
    } rvec_t;

    // reference model: queue of deliverable instructions + outstanding fetch
    ent_t        mq[$];
    bit          m_out;
    bit          m_good;
    logic [31:0] m_req_pc;
    logic [31:0] m_pc;

    // bench stimulus / memory state
    bit          cfg_rst, cfg_ready, cfg_dec, cfg_rand;
    int unsigned lat = 1;
    int unsigned pend = 0;
    logic [31:0] pend_data;
    bit          ovr = 0;
    logic [31:0] ovr_data;
    bit          redir_req = 0;
    logic [31:0] redir_target;
    logic [31:0] hs_log[$];
    ent_t        pop_log[$];
    bit          saw_bad_word = 0;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_checks();
        chk("instr_valid", 32'(instr_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("instr_raw", instr_raw, mq[0].word);
            chk("instr_pc", instr_pc, mq[0].pc);
        end
        chk("req_valid", 32'(imem_req_valid), 32'(!rst && !m_out && mq.size() < DEPTH));
        chk("req_addr", imem_req_addr, m_pc);
        if (instr_valid && instr_raw == 32'hDEAD_BEEF) saw_bad_word = 1;
    endtask

    // One clock: check outputs, drive inputs, advance memory and model, wait edge.
    task automatic step();
        bit hs, pop, resp;
        do_checks();
        if (cfg_rand) begin
            cfg_ready = ($urandom_range(0, 3) != 0);
            cfg_dec   = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 15) == 0) begin
                redir_req    = 1;
                redir_target = $urandom;
            end
        end
        resp = 0;
        if (pend == 1) begin
            resp = 1;
            pend = 0;
        end else if (pend > 1) begin
            pend--;
        end
        rst             = cfg_rst;
        imem_req_ready  = cfg_ready;
        instr_ready     = cfg_dec;
        redirect_valid  = redir_req;
        redirect_pc     = redir_target;
        imem_resp_valid = resp;
        imem_resp_data  = resp ? pend_data : $urandom;
        #1;
        if (imem_req_valid && imem_req_ready) hs_log.push_back(imem_req_addr);
        if (instr_valid && instr_ready && !redirect_valid && !rst)
            pop_log.push_back('{pc: instr_pc, word: instr_raw});

        hs  = !cfg_rst && !m_out && (mq.size() < DEPTH) && cfg_ready;
        pop = (mq.size() != 0) && cfg_dec;
        if (hs) begin
            if (cfg_rand) lat = $urandom_range(1, 3);
            pend      = lat;
            pend_data = ovr ? ovr_data : memword(m_pc);
            ovr       = 0;
        end
        if (cfg_rst) begin
            m_pc  = RST_PC;
            mq.delete();
            m_out = 0;
        end else if (redir_req) begin
            mq.delete();
            if (hs) begin
                m_out  = 1;
                m_good = 0;
            end else if (m_out && resp) begin
                m_out = 0;
            end else if (m_out) begin
                m_good = 0;
            end
            m_pc = redir_target & 32'hFFFF_FFFC;
        end else begin
            if (pop) void'(mq.pop_front());
            if (resp && m_out) begin
                if (m_good) mq.push_back('{pc: m_req_pc, word: pend_data});
                m_out = 0;
            end
            if (hs) begin
                m_out    = 1;
                m_good   = 1;
                m_req_pc = m_pc;
                m_pc     = m_pc + 32'd4;
            end
        end
        redir_req = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        pend    = 0;
        cfg_rst = 1;
        step();
        step();
        cfg_rst = 0;
    endtask

    function automatic logic [31:0] hs_at(input int i);
        return (i < hs_log.size()) ? hs_log[i] : 32'hBAD0_BAD0;
    endfunction

    function automatic logic [31:0] pop_pc_at(input int i);
        return (i < pop_log.size()) ? pop_log[i].pc : 32'hBAD0_BAD0;
    endfunction

    function automatic logic [31:0] pop_raw_at(input int i);
        return (i < pop_log.size()) ? pop_log[i].word : 32'hBAD0_BAD0;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rvec_t rtab[6];
        int    n;
        rtab[0] = '{target: 32'h0000_0203, exp_valid: 1'b1, exp_addr: 32'h0000_0200};
        rtab[1] = '{target: 32'hFFFF_FFFF, exp_valid: 1'b1, exp_addr: 32'hFFFF_FFFC};
        rtab[2] = '{target: 32'h0000_0001, exp_valid: 1'b1, exp_addr: 32'h0000_0000};
        rtab[3] = '{target: 32'h1234_5678, exp_valid: 1'b1, exp_addr: 32'h1234_5678};
        rtab[4] = '{target: 32'h8000_0002, exp_valid: 1'b1, exp_addr: 32'h8000_0000};
        rtab[5] = '{target: 32'h7FFF_FFFD, exp_valid: 1'b1, exp_addr: 32'h7FFF_FFFC};

        // reset values
        cfg_rst = 1; cfg_ready = 1; cfg_dec = 1; cfg_rand = 0;
        rst = 1; imem_req_ready = 1; instr_ready = 1; redirect_valid = 0;
        redirect_pc = '0; imem_resp_valid = 0; imem_resp_data = '0;
        @(posedge clk);
        #1;
        m_pc = RST_PC; m_out = 0; mq.delete();
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_req_addr", imem_req_addr, RST_PC);
        chk("rst_instr_raw", instr_raw, 32'd0);
        chk("rst_instr_pc", instr_pc, 32'd0);
        step();
        cfg_rst = 0;

        // sequential fetch at 1-cycle latency
        lat = 1; hs_log.delete(); pop_log.delete();
        repeat (12) step();
        for (int i = 0; i < 3; i++) begin
            chk("seq_req_addr", hs_at(i), RST_PC + 32'(4 * i));
            chk("seq_instr_pc", pop_pc_at(i), RST_PC + 32'(4 * i));
            chk("seq_instr_raw", pop_raw_at(i), memword(RST_PC + 32'(4 * i)));
        end

        // decoder stall fills buffer, then drains in order
        do_reset();
        cfg_ready = 1; cfg_dec = 0; lat = 1;
        repeat (8) step();
        chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
        chk("stall_instr_valid", 32'(instr_valid), 32'd1);
        hs_log.delete(); pop_log.delete();
        cfg_dec = 1;
        repeat (10) step();
        chk("drain_pc0", pop_pc_at(0), 32'h100);
        chk("drain_pc1", pop_pc_at(1), 32'h104);
        chk("drain_raw1", pop_raw_at(1), memword(32'h104));
        chk("resume_addr", hs_at(0), 32'h108);

        // memory not ready: request holds
        do_reset();
        cfg_ready = 0; cfg_dec = 1; hs_log.delete();
        repeat (5) begin
            step();
            chk("hold_req_valid", 32'(imem_req_valid), 32'd1);
            chk("hold_req_addr", imem_req_addr, 32'h100);
        end
        cfg_ready = 1;
        step();
        chk("hold_accept_cnt", 32'(hs_log.size()), 32'd1);
        chk("hold_accept_addr", hs_at(0), 32'h100);
        chk("hold_next_addr", imem_req_addr, 32'h104);

        // redirect alignment table (issued in IDLE, no handshake)
        do_reset();
        cfg_ready = 0; cfg_dec = 1;
        foreach (rtab[i]) begin
            redir_req = 1; redir_target = rtab[i].target;
            step();
            chk("tab_req_valid", 32'(imem_req_valid), 32'(rtab[i].exp_valid));
            chk("tab_req_addr", imem_req_addr, rtab[i].exp_addr);
        end

        // redirect while WAIT with a buffered word; pending word is discarded
        do_reset();
        cfg_ready = 1; cfg_dec = 0; lat = 1; n = 0;
        while (!(mq.size() == 1 && !m_out) && n < 10) begin step(); n++; end
        chk("wait_setup", 32'(n < 10), 32'd1);
        lat = 3; ovr = 1; ovr_data = 32'hDEAD_BEEF;
        step();
        redir_req = 1; redir_target = 32'h203; cfg_ready = 0;
        step();
        chk("wait_redir_instr_valid", 32'(instr_valid), 32'd0);
        chk("wait_redir_req_valid", 32'(imem_req_valid), 32'd0);
        hs_log.delete(); pop_log.delete(); saw_bad_word = 0;
        cfg_dec = 1; cfg_ready = 1;
        repeat (10) step();
        lat = 1;
        chk("wait_redir_addr", hs_at(0), 32'h200);
        chk("wait_redir_pc", pop_pc_at(0), 32'h200);
        chk("wait_redir_raw", pop_raw_at(0), memword(32'h200));
        chk("wait_redir_no_stale", 32'(saw_bad_word), 32'd0);

        // redirect coincident with dequeue and response
        do_reset();
        cfg_ready = 1; cfg_dec = 0; lat = 1; n = 0;
        while (!(mq.size() == 1 && m_out && pend == 1) && n < 10) begin step(); n++; end
        chk("coinc_setup", 32'(n < 10), 32'd1);
        cfg_dec = 1; cfg_ready = 0; redir_req = 1; redir_target = 32'h400;
        step();
        chk("coinc_instr_valid", 32'(instr_valid), 32'd0);
        chk("coinc_req_valid", 32'(imem_req_valid), 32'd1);
        chk("coinc_req_addr", imem_req_addr, 32'h400);
        hs_log.delete(); pop_log.delete();
        cfg_ready = 1;
        repeat (6) step();
        chk("coinc_next_addr", hs_at(0), 32'h400);
        chk("coinc_next_pc", pop_pc_at(0), 32'h400);

        // PC wrap, then reset during WAIT with a late response
        do_reset();
        cfg_ready = 0; redir_req = 1; redir_target = 32'hFFFF_FFFC;
        step();
        hs_log.delete();
        cfg_ready = 1; lat = 3;
        step();
        chk("wrap_req_addr", hs_at(0), 32'hFFFF_FFFC);
        chk("wrap_next_addr", imem_req_addr, 32'h0000_0000);
        cfg_rst = 1; cfg_ready = 0;
        step();
        chk("wait_rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("wait_rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("wait_rst_req_addr", imem_req_addr, RST_PC);
        chk("wait_rst_instr_raw", instr_raw, 32'd0);
        chk("wait_rst_instr_pc", instr_pc, 32'd0);
        cfg_rst = 0;
        repeat (4) step();
        chk("late_resp_ignored", 32'(instr_valid), 32'd0);
        hs_log.delete(); lat = 1; cfg_ready = 1; cfg_dec = 1;
        repeat (4) step();
        chk("after_rst_addr", hs_at(0), RST_PC);

        // randomized traffic against the model
        do_reset();
        cfg_rand = 1;
        repeat (1500) step();
        cfg_rand = 0; cfg_ready = 1; cfg_dec = 1; lat = 1;
        repeat (10) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
